prg_ram_writer: RTL and testbench

//  Consumes the byte stream (ioctl_download/addr/data/wr) emitted by the SD-card loader when a PRG image is

---
 rtl/prg_ram_writer_if.sv | 41 ++++
 rtl/prg_ram_writer.sv | 192 +++++++++++++++++++
 tb/tb_prg_ram_writer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prg_ram_writer_if.sv
// rtl/prg_ram_writer_if.sv - loader byte stream and RAM write port bundle
interface prg_ram_writer_if;
    logic        ioctl_download;
    logic        load_prg;
    logic [22:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_wait;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        ram_ack;

    // The writer consumes the loader stream and drives the RAM port
    modport master (
        input  ioctl_download,
        input  load_prg,
        input  ioctl_addr,
        input  ioctl_data,
        input  ioctl_wr,
        input  ram_ack,
        output ioctl_wait,
        output ram_addr,
        output ram_din,
        output ram_we
    );

    // Loader and RAM side
    modport slave (
        output ioctl_download,
        output load_prg,
        output ioctl_addr,
        output ioctl_data,
        output ioctl_wr,
        output ram_ack,
        input  ioctl_wait,
        input  ram_addr,
        input  ram_din,
        input  ram_we
    );
endinterface

// File: rtl/prg_ram_writer.sv
// rtl/prg_ram_writer.sv - PRG image stream to C64 RAM writer with BASIC pointer fixup
module prg_ram_writer #(
    parameter logic [15:0] BASIC_START = 16'h0801,
    parameter bit          PTR_FIXUP   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    prg_ram_writer_if.master         bus,
    output logic [15:0]              prg_start,
    output logic [15:0]              prg_end,
    output logic                     prg_done,
    output logic                     prg_overflow
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WR_WAIT,
        FIX,
        FIX_WAIT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_din_q, ram_din_d;
    logic        ram_we_q, ram_we_d;
    logic        ioctl_wait_q, ioctl_wait_d;
    logic [15:0] prg_start_q, prg_start_d;
    logic [15:0] prg_end_q, prg_end_d;
    logic        prg_overflow_q, prg_overflow_d;
    logic        dl_q, dl_d;
    logic [2:0]  fix_idx_q, fix_idx_d;

    logic [23:0] target;
    logic        target_ovf;
    logic        dl_rise;

    // Zero-page / BASIC pointer locations patched after a BASIC load,
    // visited low byte first for each pointer.
    function automatic logic [7:0] fix_addr(input logic [2:0] idx);
        logic [7:0] a;
        case (idx)
            3'd6:    a = 8'hAE;
            3'd7:    a = 8'hAF;
            default: a = 8'h2D + {5'd0, idx};
        endcase
        return a;
    endfunction

    // Target address computed wide so any carry past $FFFF is seen
    always_comb begin
        target     = {8'd0, prg_start_q} + ({1'b0, bus.ioctl_addr} - 24'd2);
        target_ovf = |target[23:16];
        dl_rise    = bus.ioctl_download & ~dl_q;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d        = state_q;
        ram_addr_d     = ram_addr_q;
        ram_din_d      = ram_din_q;
        ram_we_d       = ram_we_q;
        ioctl_wait_d   = ioctl_wait_q;
        prg_start_d    = prg_start_q;
        prg_end_d      = prg_end_q;
        prg_overflow_d = prg_overflow_q;
        fix_idx_d      = fix_idx_q;
        dl_d           = bus.ioctl_download;

        case (state_q)
            IDLE: begin
                if (dl_rise && bus.load_prg) begin
                    prg_overflow_d = 1'b0;
                    prg_end_d      = 16'h0000;
                    state_d        = HDR;
                end
            end

            HDR: begin
                if (!bus.ioctl_download) begin
                    state_d = DONE;
                end else if (bus.ioctl_wr) begin
                    if (bus.ioctl_addr == 23'd0) begin
                        prg_start_d[7:0] = bus.ioctl_data;
                    end else if (bus.ioctl_addr == 23'd1) begin
                        prg_start_d[15:8] = bus.ioctl_data;
                        state_d           = DATA;
                    end
                end
            end

            DATA: begin
                if (bus.ioctl_wr && !ioctl_wait_q && bus.ioctl_addr >= 23'd2) begin
                    if (target_ovf) begin
                        prg_overflow_d = 1'b1;
                    end else begin
                        ram_addr_d   = target[15:0];
                        ram_din_d    = bus.ioctl_data;
                        ram_we_d     = 1'b1;
                        ioctl_wait_d = 1'b1;
                        state_d      = WR_WAIT;
                    end
                end else if (!bus.ioctl_download) begin
                    if (PTR_FIXUP && prg_start_q == BASIC_START && prg_end_q != 16'h0000) begin
                        fix_idx_d = 3'd0;
                        state_d   = FIX;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            WR_WAIT: begin
                if (bus.ram_ack) begin
                    ram_we_d     = 1'b0;
                    ioctl_wait_d = 1'b0;
                    prg_end_d    = ram_addr_q + 16'd1;
                    state_d      = DATA;
                end
            end

            FIX: begin
                ram_addr_d = {8'h00, fix_addr(fix_idx_q)};
                ram_din_d  = fix_idx_q[0] ? prg_end_q[15:8] : prg_end_q[7:0];
                ram_we_d   = 1'b1;
                state_d    = FIX_WAIT;
            end

            FIX_WAIT: begin
                if (bus.ram_ack) begin
                    ram_we_d = 1'b0;
                    if (fix_idx_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        fix_idx_d = fix_idx_q + 3'd1;
                        state_d   = FIX;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any pending write at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ram_addr_q     <= 16'h0000;
            ram_din_q      <= 8'h00;
            ram_we_q       <= 1'b0;
            ioctl_wait_q   <= 1'b0;
            prg_start_q    <= 16'h0000;
            prg_end_q      <= 16'h0000;
            prg_overflow_q <= 1'b0;
            dl_q           <= 1'b0;
            fix_idx_q      <= 3'd0;
        end else begin
            state_q        <= state_d;
            ram_addr_q     <= ram_addr_d;
            ram_din_q      <= ram_din_d;
            ram_we_q       <= ram_we_d;
            ioctl_wait_q   <= ioctl_wait_d;
            prg_start_q    <= prg_start_d;
            prg_end_q      <= prg_end_d;
            prg_overflow_q <= prg_overflow_d;
            dl_q           <= dl_d;
            fix_idx_q      <= fix_idx_d;
        end
    end

    // Output mapping
    always_comb begin
        bus.ram_addr   = ram_addr_q;
        bus.ram_din    = ram_din_q;
        bus.ram_we     = ram_we_q;
        bus.ioctl_wait = ioctl_wait_q;
        prg_start      = prg_start_q;
        prg_end        = prg_end_q;
        prg_overflow   = prg_overflow_q;
        prg_done       = (state_q == DONE);
    end

endmodule

// File: tb/tb_prg_ram_writer.sv
// tb/tb_prg_ram_writer.sv - table-driven bench for prg_ram_writer
module tb_prg_ram_writer;

    logic        clk;
    logic        reset_n;
    logic [15:0] prg_start;
    logic [15:0] prg_end;
    logic        prg_done;
    logic        prg_overflow;

    prg_ram_writer_if bus ();

    prg_ram_writer #(.BASIC_START(16'h0801), .PTR_FIXUP(1'b1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus.master),
        .prg_start    (prg_start),
        .prg_end      (prg_end),
        .prg_done     (prg_done),
        .prg_overflow (prg_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          lp;
        logic [15:0] start;
        int          len;
        logic [7:0]  base;
        logic [7:0]  step;
        int          delay;
        int          exp_wr;
        logic [15:0] exp_start;
        logic [15:0] exp_end;
        bit          exp_ovf;
        int          exp_fix;
        int          exp_done;
    } vec_t;

    vec_t vec[7];

    int tests_run = 0;
    int fails     = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] fix_a [0:15];
    logic [7:0]  fix_d [0:15];
    int          fix_n, data_wr, done_cnt, wait_err, stab_err, hold_max, run;
    int          ack_delay, we_cnt;
    bit          in_stream;
    logic        prev_we;
    logic [15:0] prev_addr;
    logic [7:0]  prev_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests_run++;
        fails++;
        $display("FAIL %s: timeout", name);
    endtask

    function automatic bit is_fix(input logic [15:0] a);
        return (a >= 16'h002D && a <= 16'h0032) || a == 16'h00AE || a == 16'h00AF;
    endfunction

    function automatic logic [7:0] img_byte(input vec_t v, input int a);
        logic [7:0] k;
        if (a == 0) return v.start[7:0];
        if (a == 1) return v.start[15:8];
        k = 8'(a - 2);
        return v.base + v.step * k;
    endfunction

    // RAM model: acks after ack_delay extra cycles and records accepted writes
    initial begin
        bus.ram_ack = 1'b0;
        we_cnt = 0;
        forever begin
            @(negedge clk);
            bus.ram_ack = 1'b0;
            if (bus.ram_we === 1'b1) begin
                if (we_cnt >= ack_delay) begin
                    bus.ram_ack = 1'b1;
                    mem[bus.ram_addr] = bus.ram_din;
                    if (is_fix(bus.ram_addr)) begin
                        if (fix_n < 16) begin
                            fix_a[fix_n] = bus.ram_addr;
                            fix_d[fix_n] = bus.ram_din;
                        end
                        fix_n++;
                    end else begin
                        data_wr++;
                    end
                    we_cnt = 0;
                end else begin
                    we_cnt++;
                end
            end else begin
                we_cnt = 0;
            end
        end
    end

    // Observer: done pulses, wait/we relationship, held request stability
    initial begin
        prev_we = 1'b0;
        prev_addr = '0;
        prev_din = '0;
        forever begin
            @(posedge clk);
            #2;
            if (prg_done === 1'b1) done_cnt++;
            if (bus.ioctl_wait !== (in_stream && bus.ram_we)) wait_err++;
            if (bus.ram_we === 1'b1) begin
                if (prev_we && (bus.ram_addr !== prev_addr || bus.ram_din !== prev_din)) stab_err++;
                run = prev_we ? run + 1 : 1;
                if (run > hold_max) hold_max = run;
            end
            prev_we   = bus.ram_we;
            prev_addr = bus.ram_addr;
            prev_din  = bus.ram_din;
        end
    end

    task automatic clear_logs();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        fix_n = 0; data_wr = 0; done_cnt = 0; wait_err = 0;
        stab_err = 0; hold_max = 0; run = 0;
    endtask

    task automatic start_dl(input bit lp);
        @(negedge clk);
        bus.load_prg = lp;
        bus.ioctl_download = 1'b1;
        in_stream = lp;
        @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        int g = 0;
        while (bus.ioctl_wait === 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) timeout(name);
    endtask

    task automatic send_byte(input int a, input logic [7:0] d);
        wait_ready("send_wait");
        bus.ioctl_addr = 23'(a);
        bus.ioctl_data = d;
        bus.ioctl_wr = 1'b1;
        @(negedge clk);
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic end_dl();
        int g = 0;
        wait_ready("end_wait");
        bus.ioctl_download = 1'b0;
        in_stream = 1'b0;
        while (done_cnt == 0 && g < 600) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_vector(input int v);
        int derr;
        int ferr;
        logic [15:0] ea;
        logic [7:0]  ed;
        clear_logs();
        ack_delay = vec[v].delay;
        start_dl(vec[v].lp);
        for (int a = 0; a < vec[v].len; a++) send_byte(a, img_byte(vec[v], a));
        end_dl();
        derr = 0;
        for (int i = 0; i < vec[v].exp_wr; i++) begin
            if (mem[vec[v].start + 16'(i)] !== img_byte(vec[v], i + 2)) derr++;
        end
        ferr = 0;
        for (int i = 0; i < vec[v].exp_fix && i < fix_n && i < 16; i++) begin
            ea = (i == 6) ? 16'h00AE : (i == 7) ? 16'h00AF : 16'h002D + 16'(i);
            ed = i[0] ? vec[v].exp_end[15:8] : vec[v].exp_end[7:0];
            if (fix_a[i] !== ea || fix_d[i] !== ed) ferr++;
        end
        check($sformatf("v%0d prg_start", v), {16'd0, prg_start}, {16'd0, vec[v].exp_start});
        check($sformatf("v%0d prg_end", v), {16'd0, prg_end}, {16'd0, vec[v].exp_end});
        check($sformatf("v%0d prg_overflow", v), {31'd0, prg_overflow}, {31'd0, vec[v].exp_ovf});
        check($sformatf("v%0d data_writes", v), data_wr, vec[v].exp_wr);
        check($sformatf("v%0d data_values", v), derr, 0);
        check($sformatf("v%0d fix_writes", v), fix_n, vec[v].exp_fix);
        check($sformatf("v%0d fix_values", v), ferr, 0);
        check($sformatf("v%0d done_pulses", v), done_cnt, vec[v].exp_done);
        check($sformatf("v%0d wait_vs_we", v), wait_err, 0);
        check($sformatf("v%0d we_stable", v), stab_err, 0);
        check($sformatf("v%0d we_hold", v), hold_max,
              (vec[v].exp_wr + vec[v].exp_fix > 0) ? vec[v].delay + 1 : 0);
    endtask

    initial begin
        //           lp    start     len base   step   dly wr  exp_start  exp_end    ovf  fix done
        vec[0] = '{1'b0, 16'h0801,  5, 8'hAA, 8'h11, 0,  0, 16'h0000, 16'h0000, 1'b0, 0, 0};
        vec[1] = '{1'b1, 16'h0801,  5, 8'hAA, 8'h11, 1,  3, 16'h0801, 16'h0804, 1'b0, 8, 1};
        vec[2] = '{1'b1, 16'hC000, 18, 8'h10, 8'h01, 0, 16, 16'hC000, 16'hC010, 1'b0, 0, 1};
        vec[3] = '{1'b1, 16'hFFFE,  6, 8'h50, 8'h01, 2,  2, 16'hFFFE, 16'h0000, 1'b1, 0, 1};
        vec[4] = '{1'b1, 16'h1000,  5, 8'h70, 8'h05, 20, 3, 16'h1000, 16'h1003, 1'b0, 0, 1};
        vec[5] = '{1'b1, 16'h0801,  3, 8'h5A, 8'h00, 0,  1, 16'h0801, 16'h0802, 1'b0, 8, 1};
        vec[6] = '{1'b1, 16'h3412,  1, 8'h00, 8'h00, 0,  0, 16'h0812, 16'h0000, 1'b0, 0, 1};

        bus.ioctl_download = 1'b0;
        bus.load_prg = 1'b0;
        bus.ioctl_addr = '0;
        bus.ioctl_data = '0;
        bus.ioctl_wr = 1'b0;
        in_stream = 1'b0;
        ack_delay = 0;
        clear_logs();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.ram_we, bus.ioctl_wait, prg_done, prg_overflow, bus.ram_din, 8'h00},
              32'h0);
        check("reset_addrs", {bus.ram_addr, prg_start}, 32'h0);
        check("reset_end", {16'd0, prg_end}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) apply_vector(v);

        // Write strobe while ioctl_wait is high must be ignored
        clear_logs();
        ack_delay = 3;
        start_dl(1'b1);
        send_byte(0, 8'h00);
        send_byte(1, 8'h20);
        send_byte(2, 8'h11);
        check("viol_wait_high", {31'd0, bus.ioctl_wait}, 32'd1);
        bus.ioctl_addr = 23'd3;
        bus.ioctl_data = 8'h22;
        bus.ioctl_wr = 1'b1;
        @(negedge clk);
        bus.ioctl_wr = 1'b0;
        send_byte(3, 8'h33);
        end_dl();
        check("viol_writes", data_wr, 2);
        check("viol_byte0", {24'd0, mem[16'h2000]}, 32'h11);
        check("viol_byte1", {24'd0, mem[16'h2001]}, 32'h33);
        check("viol_end", {16'd0, prg_end}, 32'h2002);
        check("viol_done", done_cnt, 1);

        // Reset while a write is pending drops it asynchronously
        clear_logs();
        ack_delay = 50;
        start_dl(1'b1);
        send_byte(0, 8'h01);
        send_byte(1, 8'h08);
        send_byte(2, 8'hAA);
        check("rst_we_before", {31'd0, bus.ram_we}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_we", {31'd0, bus.ram_we}, 32'd0);
        check("rst_async_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        check("rst_async_start", {16'd0, prg_start}, 32'd0);
        bus.ioctl_download = 1'b0;
        in_stream = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_no_write", data_wr, 0);
        apply_vector(1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
